// File: rtl/vga_timing_gen_pkg.sv
// rtl/vga_timing_gen_pkg.sv - shared 1280x1024@60 raster constants and helpers
package vga_pkg;

    localparam int VGA_H_ACTIVE = 1280;
    localparam int VGA_H_FP     = 48;
    localparam int VGA_H_SYNC   = 112;
    localparam int VGA_H_BP     = 248;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_ACTIVE = 1024;
    localparam int VGA_V_FP     = 1;
    localparam int VGA_V_SYNC   = 3;
    localparam int VGA_V_BP     = 38;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int CNT_W = 11;

    function automatic logic [31:0] zext(input logic [CNT_W-1:0] value);
        return {{(32-CNT_W){1'b0}}, value};
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - pixel enable in, raster coordinates and strobes out
interface vga_timing_gen_if;

    logic        pix_ce;
    logic [31:0] X;
    logic [31:0] Y;
    logic        display;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        VGA_BLANK_N;
    logic        VGA_SYNC_N;
    logic        frame_tick;

    modport master (
        input  pix_ce,
        output X, Y, display, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, frame_tick
    );

    modport slave (
        output pix_ce,
        input  X, Y, display, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, frame_tick
    );

endinterface

// File: rtl/vga_timing_gen_axis_counter.sv
// rtl/vga_timing_gen_axis_counter.sv - one raster axis: wrapping counter plus active/sync decode
module vga_axis_counter #(
    parameter int ACTIVE = 1280,
    parameter int FP     = 48,
    parameter int SYNC   = 112,
    parameter int BP     = 248,
    parameter bit POL    = 1'b1,
    parameter int W      = 11
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         ce,
    input  logic         carry_in,
    output logic [W-1:0] count,
    output logic         carry_out,
    output logic         active,
    output logic         sync
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    localparam logic [W-1:0] L_LAST       = W'(TOTAL - 1);
    localparam logic [W-1:0] L_ACTIVE     = W'(ACTIVE);
    localparam logic [W-1:0] L_SYNC_START = W'(ACTIVE + FP);
    localparam logic [W-1:0] L_SYNC_END   = W'(ACTIVE + FP + SYNC);

    logic [W-1:0] r_count;
    logic         w_at_last;
    logic         w_in_sync;

    assign w_at_last = (r_count == L_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (ce && carry_in) begin
            r_count <= w_at_last ? '0 : r_count + 1'b1;
        end
    end

    // carry is combinational so the next axis steps on the same enabled edge as the wrap
    assign carry_out = carry_in && w_at_last;
    assign w_in_sync = (r_count >= L_SYNC_START) && (r_count < L_SYNC_END);

    assign count  = r_count;
    assign active = (r_count < L_ACTIVE);
    assign sync   = w_in_sync ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster timing generator: h/v axis counters plus aligned output register bank
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic             clk,
    input  logic             resetn,
    vga_timing_gen_if.master vif
);

    logic [CNT_W-1:0] w_h_cnt;
    logic [CNT_W-1:0] w_v_cnt;
    logic             w_h_carry;
    logic             w_v_carry_unused;
    logic             w_h_active;
    logic             w_v_active;
    logic             w_h_sync;
    logic             w_v_sync;
    logic             w_frame_start;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (HS_POL),
        .W      (CNT_W)
    ) u_h_axis (
        .clk       (clk),
        .resetn    (resetn),
        .ce        (vif.pix_ce),
        .carry_in  (1'b1),
        .count     (w_h_cnt),
        .carry_out (w_h_carry),
        .active    (w_h_active),
        .sync      (w_h_sync)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (VS_POL),
        .W      (CNT_W)
    ) u_v_axis (
        .clk       (clk),
        .resetn    (resetn),
        .ce        (vif.pix_ce),
        .carry_in  (w_h_carry),
        .count     (w_v_cnt),
        .carry_out (w_v_carry_unused),
        .active    (w_v_active),
        .sync      (w_v_sync)
    );

    assign w_frame_start = (w_h_cnt == '0) && (w_v_cnt == CNT_W'(V_ACTIVE));

    logic [31:0] r_x;
    logic [31:0] r_y;
    logic        r_display;
    logic        r_hs;
    logic        r_vs;
    logic        r_frame_tick;

    // every output samples the same pre-edge count, keeping coordinates and strobes aligned
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_x          <= '0;
            r_y          <= '0;
            r_display    <= 1'b0;
            r_hs         <= ~HS_POL;
            r_vs         <= ~VS_POL;
            r_frame_tick <= 1'b0;
        end else if (vif.pix_ce) begin
            r_x          <= zext(w_h_cnt);
            r_y          <= zext(w_v_cnt);
            r_display    <= w_h_active && w_v_active;
            r_hs         <= w_h_sync;
            r_vs         <= w_v_sync;
            r_frame_tick <= w_frame_start;
        end
    end

    assign vif.X           = r_x;
    assign vif.Y           = r_y;
    assign vif.display     = r_display;
    assign vif.VGA_HS      = r_hs;
    assign vif.VGA_VS      = r_vs;
    assign vif.VGA_BLANK_N = r_display;
    assign vif.VGA_SYNC_N  = 1'b0;
    assign vif.frame_tick  = r_frame_tick;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - bench for vga_timing_gen at default and small raster sizes
module tb_vga_timing_gen;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic        disp;
        logic        hs;
        logic        vs;
        logic        tick;
    } exp_t;

    logic clk = 1'b0;
    logic rst_d;
    logic rst_s;
    int   checks = 0;
    int   errors = 0;
    int   k_d = 0;
    int   k_s = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if vif_d ();
    vga_timing_gen_if vif_s ();

    vga_timing_gen u_dut_d (
        .clk    (clk),
        .resetn (rst_d),
        .vif    (vif_d.master)
    );

    vga_timing_gen #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HS_POL   (1'b1), .VS_POL (1'b0)
    ) u_dut_s (
        .clk    (clk),
        .resetn (rst_s),
        .vif    (vif_s.master)
    );

    // position p counts enabled edges since reset; outputs show position p after edge p+1
    function automatic exp_t model(input int p, input int ha, input int hf, input int hsw, input int hb,
                                   input int va, input int vf, input int vsw, input int vb,
                                   input bit hp, input bit vp);
        exp_t e;
        int   ht, vt, pos, h, v;
        ht  = ha + hf + hsw + hb;
        vt  = va + vf + vsw + vb;
        pos = p % (ht * vt);
        h   = pos % ht;
        v   = pos / ht;
        e.x    = h;
        e.y    = v;
        e.disp = (h < ha) && (v < va);
        e.hs   = (h >= ha + hf && h < ha + hf + hsw) ? hp : !hp;
        e.vs   = (v >= va + vf && v < va + vf + vsw) ? vp : !vp;
        e.tick = (h == 0) && (v == va);
        return e;
    endfunction

    function automatic exp_t reset_exp(input bit hp, input bit vp);
        exp_t e;
        e.x = 0; e.y = 0; e.disp = 0; e.hs = !hp; e.vs = !vp; e.tick = 0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string t);
        exp_t e;
        e = (k_d == 0) ? reset_exp(1'b1, 1'b1)
                       : model(k_d - 1, 1280, 48, 112, 248, 1024, 1, 3, 38, 1'b1, 1'b1);
        chk({t, ".X"}, vif_d.X, e.x);
        chk({t, ".Y"}, vif_d.Y, e.y);
        chk({t, ".display"}, 32'(vif_d.display), 32'(e.disp));
        chk({t, ".blank_n"}, 32'(vif_d.VGA_BLANK_N), 32'(e.disp));
        chk({t, ".hs"}, 32'(vif_d.VGA_HS), 32'(e.hs));
        chk({t, ".vs"}, 32'(vif_d.VGA_VS), 32'(e.vs));
        chk({t, ".tick"}, 32'(vif_d.frame_tick), 32'(e.tick));
        chk({t, ".sync_n"}, 32'(vif_d.VGA_SYNC_N), 32'd0);
    endtask

    task automatic chk_s(input string t);
        exp_t e;
        e = (k_s == 0) ? reset_exp(1'b1, 1'b0)
                       : model(k_s - 1, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b0);
        chk({t, ".X"}, vif_s.X, e.x);
        chk({t, ".Y"}, vif_s.Y, e.y);
        chk({t, ".display"}, 32'(vif_s.display), 32'(e.disp));
        chk({t, ".blank_n"}, 32'(vif_s.VGA_BLANK_N), 32'(e.disp));
        chk({t, ".hs"}, 32'(vif_s.VGA_HS), 32'(e.hs));
        chk({t, ".vs"}, 32'(vif_s.VGA_VS), 32'(e.vs));
        chk({t, ".tick"}, 32'(vif_s.frame_tick), 32'(e.tick));
        chk({t, ".sync_n"}, 32'(vif_s.VGA_SYNC_N), 32'd0);
    endtask

    task automatic step();
        logic ce_d, ce_s, r_d, r_s;
        ce_d = vif_d.pix_ce;
        ce_s = vif_s.pix_ce;
        r_d  = rst_d;
        r_s  = rst_s;
        @(posedge clk);
        #1;
        if (ce_d && r_d) k_d++;
        if (ce_s && r_s) k_s++;
    endtask

    initial begin
        int hs_cnt, wrap_seen, found, prev_x, prev_y, prev_k, ticks, wraps;

        rst_d = 1'b0;
        rst_s = 1'b0;
        vif_d.pix_ce = 1'b1;
        vif_s.pix_ce = 1'b0;

        // reset held with pix_ce high
        repeat (5) step();
        chk_d("reset");

        rst_d = 1'b1;
        step();
        chk_d("first_edge");
        chk("first_display", 32'(vif_d.display), 32'd1);

        // one full line plus the wrap onto line 1
        hs_cnt = 0;
        wrap_seen = 0;
        prev_x = 0;
        for (int i = 0; i < 1700; i++) begin
            step();
            chk_d("hline");
            if (vif_d.Y == 0 && vif_d.VGA_HS) hs_cnt++;
            if (vif_d.X == 1280 && vif_d.Y == 0) chk("display_fall", 32'(vif_d.display), 32'd0);
            if (prev_x == 1687 && vif_d.X == 0 && vif_d.Y == 1) wrap_seen++;
            prev_x = int'(vif_d.X);
        end
        chk("hs_width", 32'(hs_cnt), 32'd112);
        chk("h_wrap", 32'(wrap_seen), 32'd1);

        // pix_ce on alternate edges
        for (int i = 0; i < 200; i++) begin
            prev_x = int'(vif_d.X);
            vif_d.pix_ce = i[0];
            step();
            chk_d("ce_alt");
            if (!i[0]) chk("ce_hold", vif_d.X, 32'(prev_x));
        end
        vif_d.pix_ce = 1'b1;

        // asynchronous reset in mid-line
        found = 0;
        for (int i = 0; i < 4000 && found == 0; i++) begin
            step();
            chk_d("seek");
            if (vif_d.X == 700) found = 1;
        end
        chk("reach_x700", 32'(found), 32'd1);
        #3 rst_d = 1'b0;
        k_d = 0;
        #1;
        chk_d("async_reset");
        repeat (2) step();
        chk_d("reset_hold");
        rst_d = 1'b1;
        step();
        chk_d("restart");
        chk("restart_display", 32'(vif_d.display), 32'd1);

        // small raster with random pix_ce over three full frames
        rst_s = 1'b1;
        ticks = 0;
        wraps = 0;
        prev_x = 0;
        prev_y = 0;
        for (int i = 0; i < 3000 && k_s < 145; i++) begin
            vif_s.pix_ce = ($urandom_range(0, 3) != 0);
            prev_k = k_s;
            step();
            chk_s("small");
            if (k_s != prev_k) begin
                if (vif_s.frame_tick) ticks++;
                if (prev_x == 7 && prev_y == 5 && vif_s.X == 0 && vif_s.Y == 0) wraps++;
            end
            prev_x = int'(vif_s.X);
            prev_y = int'(vif_s.Y);
        end
        chk("small_reached_end", 32'(k_s), 32'd145);
        chk("small_ticks", 32'(ticks), 32'd3);
        chk("small_wraps", 32'(wraps), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
